// File: rtl/q_job_launcher.sv
// q_job_launcher: host-side front end for MyDesign. Streams gate-matrix and
// state-vector beats into the q_gates / q_state_input SRAMs, then performs the
// dut_valid/dut_ready launch handshake and reports completion or error.
//
// Handshakes:
//   in_*  : a beat transfers on a rising clk edge where in_valid && in_ready.
//           in_valid while in_ready is low is ignored (no write, no count).
//   dut_* : dut_valid rises on the first launch cycle and is held until
//           dut_ready is sampled low (acknowledge). Completion is the first
//           later cycle in which dut_ready is sampled high again.
module q_job_launcher #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_last,
  output logic              q_state_input_sram_write_enable,
  output logic [ADDR_W-1:0] q_state_input_sram_write_address,
  output logic [DATA_W-1:0] q_state_input_sram_write_data,
  output logic              q_gates_sram_write_enable,
  output logic [ADDR_W-1:0] q_gates_sram_write_address,
  output logic [DATA_W-1:0] q_gates_sram_write_data,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic              job_done,
  output logic              err_overflow,
  output logic              err_timeout,
  output logic [ADDR_W:0]   state_words,
  output logic [ADDR_W:0]   gate_words,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]  gt_cnt_q, gt_cnt_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_tmo_q, err_tmo_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic              st_we_q, st_we_d;
  logic [ADDR_W-1:0] st_addr_q, st_addr_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic              gt_we_q, gt_we_d;
  logic [ADDR_W-1:0] gt_addr_q, gt_addr_d;
  logic [DATA_W-1:0] gt_data_q, gt_data_d;

  logic              accept;
  logic              new_job;
  logic              tmo_hit;
  logic [CNT_W-1:0]  st_base;
  logic [CNT_W-1:0]  gt_base;
  logic [CNT_W-1:0]  tgt_base;
  logic              tgt_full;

  // Beats are only taken while loading; launch/run/done ignore the stream.
  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept   = in_valid && in_ready;
  assign new_job  = accept && (state_q == S_IDLE);

  // The first beat of a job sees both counters as zero, so its address is 0
  // even though the previous job's counts are still held in the registers.
  assign st_base  = new_job ? '0 : st_cnt_q;
  assign gt_base  = new_job ? '0 : gt_cnt_q;
  assign tgt_base = in_sel ? gt_base : st_base;
  assign tgt_full = (tgt_base == WORDS_MAX);

  // Next-state and Moore outputs of the job sequencer.
  always_comb begin
    state_d   = state_q;
    tmo_hit   = 1'b0;
    dut_valid = 1'b0;
    job_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = in_last ? S_LAUNCH : S_LOAD;
      end
      S_LOAD: begin
        if (accept && in_last) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        dut_valid = 1'b1;
        if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end else if (!dut_ready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A completion seen in the last allowed cycle still counts as success.
        if (dut_ready) begin
          state_d = S_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        job_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word counters, sticky errors, handshake timer and the registered write port.
  always_comb begin
    st_cnt_d  = st_cnt_q;
    gt_cnt_d  = gt_cnt_q;
    err_ovf_d = err_ovf_q;
    err_tmo_d = err_tmo_q | tmo_hit;
    st_we_d   = 1'b0;
    st_addr_d = st_addr_q;
    st_data_d = st_data_q;
    gt_we_d   = 1'b0;
    gt_addr_d = gt_addr_q;
    gt_data_d = gt_data_q;
    tmo_cnt_d = ((state_q == S_LAUNCH) || (state_q == S_RUN)) ?
                tmo_cnt_q + TMO_W'(1) : '0;
    if (new_job) begin
      st_cnt_d  = '0;
      gt_cnt_d  = '0;
      err_ovf_d = 1'b0;
      err_tmo_d = 1'b0;
    end
    if (accept) begin
      if (tgt_full) begin
        // Beat is consumed but dropped; the counter stays saturated.
        err_ovf_d = 1'b1;
      end else if (in_sel) begin
        gt_we_d   = 1'b1;
        gt_addr_d = gt_base[ADDR_W-1:0];
        gt_data_d = in_data;
        gt_cnt_d  = gt_base + CNT_W'(1);
      end else begin
        st_we_d   = 1'b1;
        st_addr_d = st_base[ADDR_W-1:0];
        st_data_d = in_data;
        st_cnt_d  = st_base + CNT_W'(1);
      end
    end
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers; write strobes clear on reset so nothing stale escapes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_cnt_q  <= '0;
      gt_cnt_q  <= '0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
      tmo_cnt_q <= '0;
      st_we_q   <= 1'b0;
      st_addr_q <= '0;
      st_data_q <= '0;
      gt_we_q   <= 1'b0;
      gt_addr_q <= '0;
      gt_data_q <= '0;
    end else begin
      st_cnt_q  <= st_cnt_d;
      gt_cnt_q  <= gt_cnt_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
      st_we_q   <= st_we_d;
      st_addr_q <= st_addr_d;
      st_data_q <= st_data_d;
      gt_we_q   <= gt_we_d;
      gt_addr_q <= gt_addr_d;
      gt_data_q <= gt_data_d;
    end
  end

  assign q_state_input_sram_write_enable  = st_we_q;
  assign q_state_input_sram_write_address = st_addr_q;
  assign q_state_input_sram_write_data    = st_data_q;
  assign q_gates_sram_write_enable        = gt_we_q;
  assign q_gates_sram_write_address       = gt_addr_q;
  assign q_gates_sram_write_data          = gt_data_q;
  assign err_overflow                     = err_ovf_q;
  assign err_timeout                      = err_tmo_q;
  assign state_words                      = st_cnt_q;
  assign gate_words                       = gt_cnt_q;
  assign dbg_state                        = state_q;

endmodule
